lift_motion: RTL

Parametrised successor to the single-car motion controller. It owns the car position for an N-floor shaft and steps one floor per move under direction commands from the dispatcher. It sequences move, settle and door-dwell phases with programmable clock counts, and reports arrival and command errors as signals rather than simulation messages. It sits between the dispatcher (direction/hold source) and the floor display/door drivers.

---
 rtl/lift_pkg.sv | 23 ++
 rtl/lift_phase_timer.sv | 35 +++
 rtl/lift_motion.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lift_pkg.sv
// Shared encodings and constants for the lift motion controller.
package lift_pkg;

   typedef enum logic [1:0] {
      DIR_STOP   = 2'b00,
      DIR_DOWN   = 2'b01,
      DIR_UP     = 2'b10,
      DIR_UPDOWN = 2'b11
   } dir_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MOVE,
      S_SETTLE,
      S_DOOR
   } state_e;

   localparam logic ON    = 1'b1;
   localparam logic OFF   = 1'b0;
   localparam int   F_FST = 1;
   localparam int   CNT_W = 32;

endpackage

// File: rtl/lift_phase_timer.sv
// Loadable down-counter shared by the move, settle and door phases.
module lift_phase_timer
   import lift_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             freeze,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!freeze) begin
         if (load)
            cnt_d = load_val;
         else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/lift_motion.sv
// Single-car motion controller: floor registers and move/settle/door FSM.
module lift_motion
   import lift_pkg::*;
#(
   parameter int          NUM_FLOORS   = 7,
   parameter int          FLOOR_W      = 3,
   parameter int unsigned CLK_PER_MOVE = 1000000000,
   parameter int unsigned CLK_PER_HOLD = 10000000,
   parameter int unsigned CLK_PER_DOOR = 10000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         direction,
   input  logic               hold,
   input  logic               estop,
   output logic [FLOOR_W-1:0] floor,
   output logic [FLOOR_W-1:0] next_floor,
   output logic               move,
   output logic               door_open,
   output logic               arrived,
   output logic               err
);

   localparam logic [FLOOR_W-1:0] F_BOT = FLOOR_W'(F_FST);
   localparam logic [FLOOR_W-1:0] F_TOP = FLOOR_W'(NUM_FLOORS);
   localparam logic [CNT_W-1:0] LD_MOVE = CNT_W'(CLK_PER_MOVE - 1);
   localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(CLK_PER_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_DOOR = CNT_W'(CLK_PER_DOOR - 1);

   state_e             state_q, state_d;
   logic [FLOOR_W-1:0] floor_q, floor_d;
   logic [FLOOR_W-1:0] next_q, next_d;
   logic               move_q, move_d;
   logic               door_q, door_d;
   logic               arrived_q, arrived_d;
   logic               err_q, err_d;
   logic               t_load;
   logic [CNT_W-1:0]   t_val;
   logic               t_zero;
   dir_e               dir;

   assign dir = dir_e'(direction);

   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      next_d    = next_q;
      move_d    = move_q;
      door_d    = door_q;
      arrived_d = OFF;
      err_d     = OFF;
      t_load    = OFF;
      t_val     = '0;
      // estop freezes everything; pulses are simply never raised
      if (!estop) begin
         unique case (state_q)
            S_IDLE: begin
               if (hold) begin
                  door_d  = ON;
                  t_load  = ON;
                  t_val   = LD_DOOR;
                  state_d = S_DOOR;
               end else begin
                  unique case (dir)
                     DIR_UP: begin
                        if (floor_q < F_TOP) begin
                           next_d  = floor_q + FLOOR_W'(1);
                           move_d  = ON;
                           t_load  = ON;
                           t_val   = LD_MOVE;
                           state_d = S_MOVE;
                        end else begin
                           err_d = ON;
                        end
                     end
                     DIR_DOWN: begin
                        if (floor_q > F_BOT) begin
                           next_d  = floor_q - FLOOR_W'(1);
                           move_d  = ON;
                           t_load  = ON;
                           t_val   = LD_MOVE;
                           state_d = S_MOVE;
                        end else begin
                           err_d = ON;
                        end
                     end
                     DIR_UPDOWN: err_d = ON;
                     default: ;
                  endcase
               end
            end
            S_MOVE: begin
               if (t_zero) begin
                  floor_d   = next_q;
                  move_d    = OFF;
                  arrived_d = ON;
                  t_load    = ON;
                  t_val     = LD_HOLD;
                  state_d   = S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (t_zero) begin
                  if (hold) begin
                     door_d  = ON;
                     t_load  = ON;
                     t_val   = LD_DOOR;
                     state_d = S_DOOR;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            S_DOOR: begin
               if (hold) begin
                  t_load = ON;
                  t_val  = LD_DOOR;
               end else if (t_zero) begin
                  door_d  = OFF;
                  state_d = S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         floor_q   <= F_BOT;
         next_q    <= F_BOT;
         move_q    <= OFF;
         door_q    <= OFF;
         arrived_q <= OFF;
         err_q     <= OFF;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         next_q    <= next_d;
         move_q    <= move_d;
         door_q    <= door_d;
         arrived_q <= arrived_d;
         err_q     <= err_d;
      end
   end

   lift_phase_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (t_load),
      .freeze   (estop),
      .load_val (t_val),
      .zero     (t_zero)
   );

   assign floor      = floor_q;
   assign next_floor = next_q;
   assign move       = move_q;
   assign door_open  = door_q;
   assign arrived    = arrived_q;
   assign err        = err_q;

endmodule
